// File: rtl/cache_mem_arb_pkg.sv
// Shared types for the cache/memory arbiter: FSM state encoding and owner ids.
package cache_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin select; req[0] is the I-cache, req[1] the D-cache.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);
    import cache_mem_arb_pkg::*;

    always_comb begin
        valid  = |req;
        winner = OWNER_I;
        if (req == 2'b11) begin
            // Tie goes to whoever was not served last.
            winner = ~last;
        end else if (req[1]) begin
            winner = OWNER_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Non-preemptive round-robin arbiter sharing one fixed-latency memory port between I- and D-cache.
module cache_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 64,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_cmd_valid,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [LINE_W-1:0] mem_cmd_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              arb_busy
);
    import cache_mem_arb_pkg::*;

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_t        state_reg, state_next;
    logic              last_reg, last_next;
    logic              owner_reg, owner_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [LINE_W-1:0] wdata_reg, wdata_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [LINE_W-1:0] ic_rdata_reg, ic_rdata_next;
    logic [LINE_W-1:0] dc_rdata_reg, dc_rdata_next;

    logic pick_valid;
    logic pick_winner;

    rr_pick2 u_pick (
        .req    ({dc_req, ic_req}),
        .last   (last_reg),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_reg     <= OWNER_D;
            owner_reg    <= OWNER_I;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            cnt_reg      <= '0;
            ic_rdata_reg <= '0;
            dc_rdata_reg <= '0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            owner_reg    <= owner_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            cnt_reg      <= cnt_next;
            ic_rdata_reg <= ic_rdata_next;
            dc_rdata_reg <= dc_rdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        owner_next    = owner_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        cnt_next      = cnt_reg;
        ic_rdata_next = ic_rdata_reg;
        dc_rdata_next = dc_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    owner_next = pick_winner;
                    if (pick_winner == OWNER_D) begin
                        we_next    = dc_we;
                        addr_next  = dc_addr;
                        wdata_next = dc_we ? dc_wdata : '0;
                    end else begin
                        we_next    = 1'b0;
                        addr_next  = ic_addr;
                        wdata_next = '0;
                    end
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = CNT_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    // Read data is valid in exactly this cycle; write-backs leave rdata alone.
                    if (!we_reg) begin
                        if (owner_reg == OWNER_D) begin
                            dc_rdata_next = mem_rdata;
                        end else begin
                            ic_rdata_next = mem_rdata;
                        end
                    end
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                last_next  = owner_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_cmd_valid = (state_reg == ISSUE);
        mem_cmd_we    = mem_cmd_valid ? we_reg : 1'b0;
        mem_cmd_addr  = mem_cmd_valid ? addr_reg : '0;
        mem_cmd_wdata = mem_cmd_valid ? wdata_reg : '0;
        ic_done       = (state_reg == RESP) && (owner_reg == OWNER_I);
        dc_done       = (state_reg == RESP) && (owner_reg == OWNER_D);
        arb_busy      = (state_reg != IDLE);
        ic_rdata      = ic_rdata_reg;
        dc_rdata      = dc_rdata_reg;
    end

endmodule
